// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that serialises 1/2/4-byte read and write requests from
// N_PORTS requesters onto a byte-wide memory port with one-cycle read latency.
module mem_port_arbiter #(
    parameter int                 N_PORTS    = 2,
    parameter logic [N_PORTS-1:0] FLUSH_MASK = {{(N_PORTS-1){1'b0}}, 1'b1}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic [N_PORTS-1:0]      req_valid,
    input  logic [N_PORTS-1:0]      req_wr,
    input  logic [2*N_PORTS-1:0]    req_size,
    input  logic [32*N_PORTS-1:0]   req_addr,
    input  logic [32*N_PORTS-1:0]   req_wdata,
    output logic [N_PORTS-1:0]      resp_done,
    output logic [31:0]             resp_data,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);
    localparam int IW = $clog2(N_PORTS);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      last_grant, gnt, pick;
    logic               any_elig;
    logic [N_PORTS-1:0] eligible;
    logic [31:0]        addr_q, wdata_q, rd_acc, rd_merge;
    logic [2:0]         len_q, cnt_q;
    logic               replay_q, replay_n;
    logic [N_PORTS-1:0] done_q;
    logic               done_rd_q;
    logic               grant_en, cnt_inc, capture, finish;
    logic               io_hold;

    function automatic logic [2:0] size_to_len(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // A port whose completion is being pulsed this cycle is not eligible again yet.
    assign eligible = req_valid & ~done_q;
    assign io_hold  = (addr_q[17:16] == 2'b11) && io_buffer_full;

    always_comb begin
        int            idx;
        logic [IW-1:0] ix;
        pick     = last_grant;
        any_elig = 1'b0;
        idx      = 0;
        ix       = '0;
        for (int off = 1; off <= N_PORTS; off++) begin
            idx = (int'(last_grant) + off) % N_PORTS;
            ix  = IW'(idx);
            if (!any_elig && eligible[ix]) begin
                any_elig = 1'b1;
                pick     = ix;
            end
        end
    end

    // Byte returned by memory belongs to the address issued one cycle earlier.
    always_comb begin
        rd_merge = rd_acc;
        case (cnt_q)
            3'd1:    rd_merge[7:0]   = mem_din;
            3'd2:    rd_merge[15:8]  = mem_din;
            3'd3:    rd_merge[23:16] = mem_din;
            3'd4:    rd_merge[31:24] = mem_din;
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        grant_en = 1'b0;
        cnt_inc  = 1'b0;
        capture  = 1'b0;
        finish   = 1'b0;
        replay_n = replay_q;
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (rdy && any_elig) begin
                    grant_en = 1'b1;
                    state_n  = req_wr[pick] ? WRITE : READ;
                end
            end
            READ: begin
                // After a stall the byte whose data was lost is issued again first.
                mem_a = (replay_q && rdy) ? addr_q + 32'(cnt_q) - 32'd1
                                          : addr_q + 32'(cnt_q);
                if (!rdy) begin
                    if (cnt_q != 3'd0) replay_n = 1'b1;
                end else if (flush && FLUSH_MASK[gnt]) begin
                    state_n  = IDLE;
                    replay_n = 1'b0;
                end else if (replay_q) begin
                    replay_n = 1'b0;
                end else begin
                    capture = (cnt_q != 3'd0);
                    if (cnt_q == len_q) begin
                        state_n = IDLE;
                        finish  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            WRITE: begin
                mem_a    = addr_q + 32'(cnt_q);
                mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                if (rdy && !io_hold) begin
                    mem_wr = 1'b1;
                    if (cnt_q == len_q - 3'd1) begin
                        state_n = IDLE;
                        finish  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IW'(N_PORTS - 1);
            gnt        <= '0;
            cnt_q      <= '0;
            replay_q   <= 1'b0;
            done_q     <= '0;
            done_rd_q  <= 1'b0;
            resp_data  <= '0;
        end else begin
            replay_q <= replay_n;
            if (rdy) begin
                done_q    <= '0;
                done_rd_q <= 1'b0;
                if (grant_en) begin
                    last_grant <= pick;
                    gnt        <= pick;
                    cnt_q      <= '0;
                end else if (cnt_inc) begin
                    cnt_q <= cnt_q + 3'd1;
                end else if (state_n == IDLE) begin
                    cnt_q <= '0;
                end
                if (finish) begin
                    done_q[gnt] <= 1'b1;
                    done_rd_q   <= (state == READ);
                    resp_data   <= (state == READ) ? rd_merge : '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (grant_en) begin
                addr_q  <= req_addr[32*pick +: 32];
                wdata_q <= req_wdata[32*pick +: 32];
                len_q   <= size_to_len(req_size[2*pick +: 2]);
                rd_acc  <= '0;
            end else if (capture) begin
                rd_acc <= rd_merge;
            end
        end
    end

    // A flush landing on a masked port's read completion still kills the pulse.
    assign resp_done = (done_rd_q && flush) ? (done_q & ~FLUSH_MASK) : done_q;

endmodule
